// File: rtl/cpx_accum_dump.sv
// Coherent integrate-and-dump for one CAF bin: sums acc_len accepted complex products
// and presents each block sum in a one-deep valid/ready output register.
module cpx_accum_dump #(
  parameter  int i_bits     = 24,
  parameter  int q_bits     = 24,
  parameter  int acc_len    = 1024,
  localparam int cnt_bits   = $clog2(acc_len),
  localparam int out_i_bits = i_bits + cnt_bits,
  localparam int out_q_bits = q_bits + cnt_bits
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         m_axis_i_tvalid,
  input  logic signed [i_bits-1:0]     i,
  input  logic                         m_axis_q_tvalid,
  input  logic signed [q_bits-1:0]     q,
  output logic                         s_axis_acc_tvalid,
  input  logic                         s_axis_acc_tready,
  output logic signed [out_i_bits-1:0] acc_i,
  output logic signed [out_q_bits-1:0] acc_q,
  output logic [cnt_bits-1:0]          sample_cnt,
  output logic                         dropped
);

  typedef enum logic {ACCUM, LAST} state_t;

  state_t                       state;
  logic                         accept;
  logic signed [out_i_bits-1:0] sum_i_p0, sum_i_nxt, add_i, dump_i_nxt;
  logic signed [out_q_bits-1:0] sum_q_p0, sum_q_nxt, add_q, dump_q_nxt;
  logic [cnt_bits-1:0]          cnt_nxt;
  logic                         vld_nxt, drop_nxt;

  function automatic logic signed [out_i_bits-1:0] sext_i(input logic signed [i_bits-1:0] x);
    return out_i_bits'(x);
  endfunction

  function automatic logic signed [out_q_bits-1:0] sext_q(input logic signed [q_bits-1:0] x);
    return out_q_bits'(x);
  endfunction

  // Block position is carried entirely by sample_cnt; the state is a decode of it.
  always_comb begin
    state = (sample_cnt == cnt_bits'(acc_len - 1)) ? LAST : ACCUM;
  end

  assign accept = m_axis_i_tvalid & m_axis_q_tvalid & ~clear;
  assign add_i  = sum_i_p0 + sext_i(i);
  assign add_q  = sum_q_p0 + sext_q(q);

  always_comb begin
    sum_i_nxt  = sum_i_p0;
    sum_q_nxt  = sum_q_p0;
    dump_i_nxt = acc_i;
    dump_q_nxt = acc_q;
    cnt_nxt    = sample_cnt;
    vld_nxt    = s_axis_acc_tvalid & ~s_axis_acc_tready;
    drop_nxt   = dropped;
    if (clear) begin
      sum_i_nxt = '0;
      sum_q_nxt = '0;
      cnt_nxt   = '0;
      vld_nxt   = 1'b0;
      drop_nxt  = 1'b0;
    end else if (accept) begin
      if (state == LAST) begin
        dump_i_nxt = add_i;
        dump_q_nxt = add_q;
        sum_i_nxt  = '0;
        sum_q_nxt  = '0;
        cnt_nxt    = '0;
        vld_nxt    = 1'b1;
        // Overwriting a result nobody took this cycle loses it.
        if (s_axis_acc_tvalid & ~s_axis_acc_tready) drop_nxt = 1'b1;
      end else begin
        sum_i_nxt = add_i;
        sum_q_nxt = add_q;
        cnt_nxt   = sample_cnt + cnt_bits'(1);
      end
    end
  end

  // p0: accumulator and dump register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_i_p0          <= '0;
      sum_q_p0          <= '0;
      acc_i             <= '0;
      acc_q             <= '0;
      sample_cnt        <= '0;
      s_axis_acc_tvalid <= 1'b0;
      dropped           <= 1'b0;
    end else begin
      sum_i_p0          <= sum_i_nxt;
      sum_q_p0          <= sum_q_nxt;
      acc_i             <= dump_i_nxt;
      acc_q             <= dump_q_nxt;
      sample_cnt        <= cnt_nxt;
      s_axis_acc_tvalid <= vld_nxt;
      dropped           <= drop_nxt;
    end
  end

endmodule
